priority_encoder_rr: RTL
========================

PRIORITY_ENCODER_RR -- requirements
Module: priority_encoder_rr

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-low reset: `clk` is the clock, `reset_b` is the reset.
REQ-002 Parameter N SHALL be the number of request inputs; default 8; legal range is 2 or more.
REQ-003 Parameter W SHALL be the code width; default $clog2(N), which is 3 at the default N.
REQ-004 `clk` SHALL be an input, 1 bit wide; the rising edge is active.
REQ-005 `reset_b` SHALL be an input, 1 bit wide; it is a synchronous, active-low reset.
REQ-006 `D` SHALL be an input, N bits wide, carrying the request vector; bit N-1 is the highest fixed priority.
REQ-007 `load` SHALL be an input, 1 bit wide, requesting capture of D into the pending register.
REQ-008 `mode` SHALL be an input, 1 bit wide, selecting the priority scheme: 0 = fixed priority, 1 = round-robin.
REQ-009 `out_ready` SHALL be an input, 1 bit wide; it is the consumer's acceptance signal for `code`.
REQ-010 `V` SHALL be an output, 1 bit wide, indicating that `code` is valid (at least one bit is pending).
REQ-011 `code` SHALL be an output, W bits wide, giving the index of the currently selected pending request.
REQ-012 `busy` SHALL be an output, 1 bit wide, equal to V; `load` is ignored while `busy` is 1.
REQ-013 `done` SHALL be an output, 1 bit wide: a one-cycle pulse in the cycle after the last pending bit is accepted.

Function
REQ-014 The block SHALL hold an N-bit `pending` register and a W-bit search pointer `ptr`.
REQ-015 V SHALL equal (pending != 0); V, code and busy SHALL depend only on registered state (Moore outputs).
REQ-016 In fixed mode, code SHALL be the highest set index of pending.
REQ-017 In round-robin mode, code SHALL be the first set index of pending found by searching downward from ptr, wrapping from 0 to N-1.
REQ-018 A load SHALL be accepted only when pending == 0; on acceptance, pending <= D on the next edge, with first V at latency 1.
REQ-019 A load with D == 0 SHALL leave pending at 0 and SHALL NOT pulse `done`.
REQ-020 When V and out_ready are both 1 (a handshake), the bit at index `code` SHALL be cleared on the next edge.
REQ-021 On a handshake, ptr SHALL become (code == 0) ? N-1 : code-1, in both modes.
REQ-022 ptr SHALL persist across batches; it changes only on a handshake or a reset.
REQ-023 When V=1 and out_ready=0, code and pending SHALL hold stable.
REQ-024 A load asserted in the same cycle as the final handshake SHALL be ignored, because pending is nonzero in that cycle.
REQ-025 `done` SHALL be registered: it is 1 for exactly the one cycle after a handshake that clears the last pending bit.
REQ-026 A change of `mode` mid-batch SHALL take effect on the selection made from the next registered state.
REQ-027 Throughput SHALL be one code per cycle while out_ready is held at 1.

Reset
REQ-028 When reset_b=0 at a clock edge, the block SHALL set pending=0, ptr=N-1 and done=0; V, busy and code therefore read 0 in the following cycle.
REQ-029 A reset asserted mid-batch SHALL discard all pending requests; no `done` pulse SHALL follow the reset.

Structure
REQ-030 A shared package SHALL hold the constants MODE_FIXED=1'b0 and MODE_RR=1'b1 and the default N.
REQ-031 The block SHALL contain one combinational sub-module, `prio_sel`, taking (vector, start index) and returning (index, found); priority_encoder_rr instantiates it once.
REQ-032 In fixed mode, the start index fed to `prio_sel` SHALL be N-1.

Verification (N=8)
REQ-033 Reset, then load D=8'b0000_0000 -> V=0, done=0 for 10 cycles.
REQ-034 Fixed mode, out_ready=1, load 8'b1001_0110 -> code 7,4,2,1 on consecutive cycles; done=1 in the cycle after code 1 is accepted.
REQ-035 Load 8'b0000_0011 with out_ready=0 for 3 cycles -> code=1 and V=1 held for those cycles; then out_ready=1 -> code 1, then 0, then V=0.
REQ-036 Batch 8'b0001_0000 granted (ptr becomes 3), then load 8'b1000_1000 -> fixed mode grants 7 then 3; round-robin mode grants 3 then 7.
REQ-037 Load 8'b0000_0001 mid-batch, and again on the final-handshake cycle -> both loads ignored and pending is unchanged.
REQ-038 Reset asserted after 1 grant of 8'b1111_0000 -> V=0 on the next cycle, no done pulse; a following load of 8'b1000_0001 grants 7 first in round-robin mode.

Source files
------------

// File: rtl/priority_encoder_rr_pkg.sv
// ---------------------------------------------------------------------------
// priority_encoder_rr_pkg
//   Shared constants for the pending-request priority encoder.
//   - MODE_FIXED / MODE_RR : encodings of the `mode` input.
//   - PE_N_DEFAULT         : default number of request inputs.
// ---------------------------------------------------------------------------
package priority_encoder_rr_pkg;

  localparam logic MODE_FIXED   = 1'b0;
  localparam logic MODE_RR      = 1'b1;

  localparam int   PE_N_DEFAULT = 8;

endpackage : priority_encoder_rr_pkg

// File: rtl/priority_encoder_rr_prio_sel.sv
// ---------------------------------------------------------------------------
// prio_sel
//   Purely combinational wrap-around priority search. Starting at index
//   `start` and walking downward (start, start-1, ..., 0, N-1, ...), returns
//   the first set bit of `vec`.
//   Ports:
//     vec   [N-1:0]  request vector to search
//     start [W-1:0]  first index examined (must be < N)
//     idx   [W-1:0]  index of the first set bit found (0 when none)
//     found          1 when vec has at least one set bit
// ---------------------------------------------------------------------------
module prio_sel #(
  parameter int N = 8,
  parameter int W = $clog2(N)
) (
  input  logic [N-1:0] vec,
  input  logic [W-1:0] start,
  output logic [W-1:0] idx,
  output logic         found
);

  always_comb begin
    int          j;
    logic [W-1:0] jj;
    idx   = '0;
    found = 1'b0;
    // Walk from the farthest candidate back to `start`, so the last hit
    // written is the one nearest to `start` in downward search order.
    for (int k = N - 1; k >= 0; k--) begin
      j = int'(start) - k;
      if (j < 0) begin
        j = j + N;
      end
      jj = W'(j);
      if (vec[jj]) begin
        idx   = jj;
        found = 1'b1;
      end
    end
  end

endmodule : prio_sel

// File: rtl/priority_encoder_rr.sv
// ---------------------------------------------------------------------------
// priority_encoder_rr
//   Captures a request vector into a pending register and hands the pending
//   indices out one at a time, either highest-index-first (fixed mode) or
//   round-robin, searching downward from a pointer just below the last grant.
//
//   Handshake: `V` is the valid for `code`; `out_ready` is the consumer's
//   ready. A transfer happens in every cycle where V && out_ready at the
//   rising edge. While V=1 and out_ready=0, code and the pending set hold.
//   V/code/busy are Moore outputs derived only from registered state.
//
//   Ports:
//     clk        clock, rising edge active
//     reset_b    synchronous active-low reset
//     D [N-1:0]  request vector, captured on load when nothing is pending
//     load       capture request (ignored while busy)
//     mode       0 = fixed priority, 1 = round-robin
//     out_ready  consumer accepts code this cycle
//     V          code is valid (pending != 0)
//     code [W-1:0] selected pending index
//     busy       same as V
//     done       one-cycle pulse after the last pending bit is accepted
// ---------------------------------------------------------------------------
module priority_encoder_rr
  import priority_encoder_rr_pkg::*;
#(
  parameter int N = PE_N_DEFAULT,
  parameter int W = $clog2(N)
) (
  input  logic         clk,
  input  logic         reset_b,
  input  logic [N-1:0] D,
  input  logic         load,
  input  logic         mode,
  input  logic         out_ready,
  output logic         V,
  output logic [W-1:0] code,
  output logic         busy,
  output logic         done
);

  localparam logic [W-1:0] PTR_TOP = W'(N - 1);

  logic [N-1:0] pending_q, pending_d;
  logic [W-1:0] ptr_q,     ptr_d;
  logic         done_q,    done_d;

  logic [W-1:0] sel_start;
  logic [W-1:0] sel_idx;
  logic         sel_found;
  logic         handshake;
  logic [N-1:0] clr_mask;
  logic [N-1:0] pending_after_grant;

  // Fixed mode always searches from the top index; round-robin resumes
  // from the persistent pointer.
  assign sel_start = (mode == MODE_FIXED) ? PTR_TOP : ptr_q;

  prio_sel #(
    .N (N),
    .W (W)
  ) u_prio_sel (
    .vec   (pending_q),
    .start (sel_start),
    .idx   (sel_idx),
    .found (sel_found)
  );

  always_comb begin
    handshake           = sel_found && out_ready;
    clr_mask            = {{(N-1){1'b0}}, 1'b1} << sel_idx;
    pending_after_grant = pending_q & ~clr_mask;

    pending_d = pending_q;
    ptr_d     = ptr_q;
    done_d    = 1'b0;

    // A load and a handshake can never coincide: a handshake needs a
    // nonzero pending set, a load needs an empty one.
    if (pending_q == '0) begin
      if (load) begin
        pending_d = D;
      end
    end else if (handshake) begin
      pending_d = pending_after_grant;
      ptr_d     = (sel_idx == '0) ? PTR_TOP : (sel_idx - W'(1));
      done_d    = (pending_after_grant == '0);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_b) begin
      pending_q <= '0;
      ptr_q     <= PTR_TOP;
      done_q    <= 1'b0;
    end else begin
      pending_q <= pending_d;
      ptr_q     <= ptr_d;
      done_q    <= done_d;
    end
  end

  assign V    = sel_found;
  assign busy = sel_found;
  assign code = sel_found ? sel_idx : '0;
  assign done = done_q;

endmodule : priority_encoder_rr
